// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the ROM combinationally and
// queues {pc, instr} pairs in a 2-entry buffer toward decode.
module inst_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr
);

   localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4 - 1) & 32'hFFFF_FFFC;

   logic [31:0] pc;
   logic [31:0] buf_pc    [2];
   logic [31:0] buf_instr [2];
   logic [1:0]  count;
   logic        wr_ptr;
   logic        rd_ptr;
   logic        pop;
   logic        push;

   assign imem_addr = pc;
   assign if_valid  = (count != 2'd0) && !redirect_valid;
   assign if_pc     = buf_pc[rd_ptr];
   assign if_instr  = buf_instr[rd_ptr];

   // if_valid is already masked by redirect, so a redirect cycle can never pop
   assign pop  = if_valid && if_ready;
   assign push = !redirect_valid && ((count != 2'd2) || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= RESET_PC;
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else if (redirect_valid) begin
         pc     <= redirect_pc & PC_MASK;
         count  <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            pc     <= (pc + 32'd4) & PC_MASK;
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Buffer payload needs no reset; it is only observed when count is non-zero
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr]    <= pc;
         buf_instr[wr_ptr] <= imem_data;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized
// traffic checked against a queue-based model of the fetch buffer.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int unsigned MEM_WORDS = 64;
   localparam logic [31:0] SPAN      = 32'(MEM_WORDS * 4);

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] q[$];
   logic [31:0] mpc;

   inst_fetch #(.RESET_PC(RESET_PC), .MEM_WORDS(MEM_WORDS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
   );

   // ROM contents: word k holds 0x1000_0000 + k
   assign imem_data = 32'h1000_0000 + ((imem_addr % SPAN) >> 2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + ((a % SPAN) >> 2);
   endfunction

   task automatic drive(input logic r, input logic rv, input logic [31:0] rp);
      if_ready       = r;
      redirect_valid = rv;
      redirect_pc    = rp;
      #1;
   endtask

   // Advance one clock and update the behavioural model with the inputs in effect.
   task automatic tick();
      logic mv, mpop, mpush;
      @(posedge clk);
      mv    = (q.size() != 0) && !redirect_valid;
      mpop  = mv && if_ready;
      mpush = !redirect_valid && ((q.size() < 2) || mpop);
      if (redirect_valid) begin
         q.delete();
         mpc = (redirect_pc % SPAN) & 32'hFFFF_FFFC;
      end else begin
         if (mpop) void'(q.pop_front());
         if (mpush) begin
            q.push_back(mpc);
            mpc = (mpc + 32'd4) % SPAN;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      q.delete();
      mpc = RESET_PC;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b0, '0);
      @(posedge clk);
      #2;
      total_cnt++;
      if (if_valid !== 1'b0) $display("FAIL reset_valid: if_valid=%0b expected 0", if_valid);
      else pass_cnt++;
      total_cnt++;
      if (imem_addr !== RESET_PC) $display("FAIL reset_addr: imem_addr=%h expected %h", imem_addr, RESET_PC);
      else pass_cnt++;
   endtask

   task automatic test_sequential();
      do_reset();
      drive(1'b1, 1'b0, '0);
      total_cnt++;
      if (if_valid !== 1'b0) $display("FAIL seq_first_cycle: if_valid=%0b expected 0", if_valid);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         tick();
         drive(1'b1, 1'b0, '0);
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || if_instr !== 32'h1000_0000 + 32'(i))
            $display("FAIL seq_fetch[%0d]: valid=%0b pc=%h instr=%h expected 1 %h %h",
                     i, if_valid, if_pc, if_instr, 32'(4 * i), 32'h1000_0000 + 32'(i));
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      drive(1'b1, 1'b0, '0);
      repeat (3) tick();
      drive(1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         tick();
         drive(1'b0, 1'b0, '0);
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== 32'h8 || imem_addr !== 32'h10)
            $display("FAIL bp_hold[%0d]: valid=%0b pc=%h addr=%h expected 1 00000008 00000010",
                     i, if_valid, if_pc, imem_addr);
         else pass_cnt++;
      end
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, '0);
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== 32'(8 + 4 * k) || if_instr !== 32'h1000_0002 + 32'(k))
            $display("FAIL bp_release[%0d]: valid=%0b pc=%h instr=%h expected 1 %h %h",
                     k, if_valid, if_pc, if_instr, 32'(8 + 4 * k), 32'h1000_0002 + 32'(k));
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_redirect();
      do_reset();
      drive(1'b0, 1'b0, '0);
      tick();
      tick();
      drive(1'b1, 1'b1, 32'h0000_0022);
      total_cnt++;
      if (if_valid !== 1'b0) $display("FAIL redir_mask: if_valid=%0b expected 0", if_valid);
      else pass_cnt++;
      tick();
      drive(1'b1, 1'b0, '0);
      total_cnt++;
      if (if_valid !== 1'b0 || imem_addr !== 32'h20)
         $display("FAIL redir_flush: valid=%0b addr=%h expected 0 00000020", if_valid, imem_addr);
      else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
         tick();
         drive(1'b1, 1'b0, '0);
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== 32'(32'h20 + 4 * k) || if_instr !== 32'h1000_0008 + 32'(k))
            $display("FAIL redir_target[%0d]: valid=%0b pc=%h instr=%h expected 1 %h %h",
                     k, if_valid, if_pc, if_instr, 32'(32'h20 + 4 * k), 32'h1000_0008 + 32'(k));
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pcs [4];
      exp_pcs = '{32'hF8, 32'hFC, 32'h00, 32'h04};
      drive(1'b1, 1'b1, 32'h0000_00F8);
      tick();
      drive(1'b1, 1'b0, '0);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b0, '0);
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== exp_pcs[k] || if_instr !== rom_word(exp_pcs[k]))
            $display("FAIL wrap[%0d]: valid=%0b pc=%h instr=%h expected 1 %h %h",
                     k, if_valid, if_pc, if_instr, exp_pcs[k], rom_word(exp_pcs[k]));
         else pass_cnt++;
         tick();
      end
      drive(1'b1, 1'b1, 32'h0000_0104);
      tick();
      drive(1'b1, 1'b0, '0);
      tick();
      drive(1'b1, 1'b0, '0);
      total_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h1000_0001)
         $display("FAIL wrap_redirect: valid=%0b pc=%h instr=%h expected 1 00000004 10000001",
                  if_valid, if_pc, if_instr);
      else pass_cnt++;
   endtask

   task automatic test_full_pop();
      do_reset();
      drive(1'b0, 1'b0, '0);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, '0);
         // full buffer means the fetch address runs two words ahead of the head
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== 32'(4 * i) || imem_addr !== 32'(4 * i + 8))
            $display("FAIL full_pop[%0d]: valid=%0b pc=%h addr=%h expected 1 %h %h",
                     i, if_valid, if_pc, imem_addr, 32'(4 * i), 32'(4 * i + 8));
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b0, 1'b0, '0);
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if (if_valid !== 1'b0 || imem_addr !== RESET_PC)
         $display("FAIL reset_mid: valid=%0b addr=%h expected 0 %h", if_valid, imem_addr, RESET_PC);
      else pass_cnt++;
      q.delete();
      mpc = RESET_PC;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      drive(1'b1, 1'b0, '0);
      for (int k = 0; k < 3; k++) begin
         tick();
         drive(1'b1, 1'b0, '0);
         total_cnt++;
         if (if_valid !== 1'b1 || if_pc !== RESET_PC + 32'(4 * k))
            $display("FAIL reset_restart[%0d]: valid=%0b pc=%h expected 1 %h",
                     k, if_valid, if_pc, RESET_PC + 32'(4 * k));
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic r, rv, exp_v;
      logic [31:0] rp;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 9) == 0);
         rp = $urandom;
         drive(r, rv, rp);
         exp_v = (q.size() != 0) && !rv;
         total_cnt++;
         if (if_valid !== exp_v || imem_addr !== mpc)
            $display("FAIL rand_ctrl[%0d]: valid=%0b addr=%h expected %0b %h",
                     i, if_valid, imem_addr, exp_v, mpc);
         else pass_cnt++;
         if (exp_v) begin
            total_cnt++;
            if (if_pc !== q[0] || if_instr !== rom_word(q[0]))
               $display("FAIL rand_head[%0d]: pc=%h instr=%h expected %h %h",
                        i, if_pc, if_instr, q[0], rom_word(q[0]));
            else pass_cnt++;
         end
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequential();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
